// File: rtl/dma_wb.sv
// dma_wb: Wishbone bus-master DMA engine.
// The CPU programs it through a four-register slave window. It then copies LEN
// 32-bit words from SRC to DST on the system bus and can raise a level interrupt
// when the copy completes.
// Optional build macro DMA_FILL_EN adds fill mode (CTRL bit3). In fill mode every
// DST word is written with the SRC register value and no read cycles are issued.
//
// Handshake (both ports follow classic Wishbone):
//   A request is cyc & stb.
//   The responder raises ack for exactly one cycle, and the request completes on
//   that cycle.
//   Address, data and we stay stable from strobe assertion until the ack cycle.
//   This master then drops cyc/stb for at least one cycle before its next request.
//   The slave port acks one cycle after a request.
//   It never acks in the cycle that follows an ack, so a held strobe gets one ack
//   every two cycles.
//   Slave writes commit on the edge that ends the ack cycle.

module dma_wb #(
    parameter int LEN_BITS = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // CPU-facing slave register window
    input  logic [25:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    // system bus master
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    output logic        int_o,
    // current FSM state (0 idle, 1 read phase, 2 write phase)
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t              state;

    // programmed registers (addresses held as word addresses)
    logic [29:0]         src_reg;
    logic [29:0]         dst_reg;
    logic [LEN_BITS-1:0] len_reg;
    logic                ien;
    logic                done;

    // working copies used during a transfer
    logic [31:0]         cur_src;
    logic [31:0]         cur_dst;
    logic [LEN_BITS-1:0] cnt;
    logic [31:0]         data_buf;

    logic                busy;
    logic                slv_req;
    logic                slv_wr;
    logic                start_req;
    logic                done_clr;
    logic                fill_bit;
    logic [31:0]         rd_mux;
    logic                unused_slv;

`ifdef DMA_FILL_EN
    logic [1:0]          src_lo;      // low SRC bits, kept only as fill data
    logic                fill_reg;
    logic                fill_mode;   // fill flag latched at START
    assign fill_bit = fill_reg;
`else
    assign fill_bit = 1'b0;
`endif

    // Only the register index is decoded; byte selects do not matter for
    // full-word registers.
    assign unused_slv = ^{wb_adr_i[25:2], wb_sel_i};

    assign busy      = (state != S_IDLE);
    assign slv_req   = wb_cyc_i & wb_stb_i;
    assign slv_wr    = slv_req & wb_ack_o & wb_we_i;
    assign start_req = slv_wr && (wb_adr_i[1:0] == 2'd3) && wb_dat_i[0];
    assign done_clr  = slv_wr && (wb_adr_i[1:0] == 2'd3) && wb_dat_i[2];

    assign int_o     = done & ien;
    assign wbm_sel_o = 4'b1111;
    assign dbg_state = state;

    // Read mux for the register window.
    always_comb begin
        rd_mux = 32'd0;
        case (wb_adr_i[1:0])
            2'd0:    rd_mux = {src_reg, 2'b00};
            2'd1:    rd_mux = {dst_reg, 2'b00};
            2'd2:    rd_mux = 32'(len_reg);
            default: rd_mux = {28'd0, fill_bit, done, ien, busy};
        endcase
    end

    // Slave ack generation; read data is captured with the ack so it is valid
    // while ack is high.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            wb_ack_o <= slv_req & ~wb_ack_o;
            wb_dat_o <= (slv_req & ~wb_ack_o) ? rd_mux : 32'd0;
        end
    end

    // Programmed registers.
    // Address and length are frozen while a transfer runs; IEN stays writable.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            src_reg  <= 30'd0;
            dst_reg  <= 30'd0;
            len_reg  <= '0;
            ien      <= 1'b0;
`ifdef DMA_FILL_EN
            src_lo   <= 2'd0;
            fill_reg <= 1'b0;
`endif
        end else if (slv_wr) begin
            case (wb_adr_i[1:0])
                2'd0: if (!busy) begin
                    src_reg <= wb_dat_i[31:2];
`ifdef DMA_FILL_EN
                    src_lo  <= wb_dat_i[1:0];
`endif
                end
                2'd1: if (!busy) dst_reg <= wb_dat_i[31:2];
                2'd2: if (!busy) len_reg <= wb_dat_i[LEN_BITS-1:0];
                default: begin
                    ien <= wb_dat_i[1];
`ifdef DMA_FILL_EN
                    if (!busy) fill_reg <= wb_dat_i[3];
`endif
                end
            endcase
        end
    end

    // Transfer FSM with registered master outputs and the DONE flag.
    // A DONE set in the same cycle as a clear takes priority because it is
    // assigned later.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= S_IDLE;
            cur_src   <= 32'd0;
            cur_dst   <= 32'd0;
            cnt       <= '0;
            data_buf  <= 32'd0;
            done      <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
`ifdef DMA_FILL_EN
            fill_mode <= 1'b0;
`endif
        end else begin
            if (done_clr) done <= 1'b0;
            case (state)
                S_IDLE: begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    wbm_we_o  <= 1'b0;
                    if (start_req) begin
                        cur_src <= {src_reg, 2'b00};
                        cur_dst <= {dst_reg, 2'b00};
                        cnt     <= len_reg;
                        if (len_reg == '0) begin
                            done <= 1'b1;
                        end
`ifdef DMA_FILL_EN
                        else if (wb_dat_i[3]) begin
                            fill_mode <= 1'b1;
                            data_buf  <= {src_reg, src_lo};
                            state     <= S_WR;
                        end else begin
                            fill_mode <= 1'b0;
                            state     <= S_RD;
                        end
`else
                        else begin
                            state <= S_RD;
                        end
`endif
                    end
                end
                S_RD: begin
                    if (!wbm_stb_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b0;
                        wbm_adr_o <= cur_src;
                    end else if (wbm_ack_i) begin
                        data_buf  <= wbm_dat_i;
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= S_WR;
                    end
                end
                S_WR: begin
                    if (!wbm_stb_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        wbm_adr_o <= cur_dst;
                        wbm_dat_o <= data_buf;
                    end else if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        cnt       <= cnt - LEN_BITS'(1);
                        cur_dst   <= cur_dst + 32'd4;
`ifdef DMA_FILL_EN
                        if (!fill_mode) cur_src <= cur_src + 32'd4;
`else
                        cur_src   <= cur_src + 32'd4;
`endif
                        if (cnt == LEN_BITS'(1)) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
`ifdef DMA_FILL_EN
                            state <= fill_mode ? S_WR : S_RD;
`else
                            state <= S_RD;
`endif
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_wb.sv
// Bench for dma_wb.
// A memory slave with random wait states serves the master port. A reference
// model turns each programmed transfer into the list of bus cycles it must
// produce, computed as plain sequential word copies over a model memory. One
// monitor checks every master cycle against that list and against the bus rules.
module tb_dma_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [25:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i;
  logic        int_o;
  logic [1:0]  dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  dma_wb #(.LEN_BITS(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_ack_i(wbm_ack_i), .int_o(int_o),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  logic [64:0] exp_q[$];                    // {we, adr, dat}
  logic [31:0] bus_mem[logic [31:0]];       // what the slave holds
  logic [31:0] ref_mem[logic [31:0]];       // what the model says it must hold
  int max_wait = 0;
  bit fixed_wait = 1'b0;
  int cyc_cycles = 0;
  int wr_seen = 0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, expv);
    end
  endtask

  // Background contents for never-written memory.
  function automatic logic [31:0] rom_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : rom_val(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : rom_val(a);
  endfunction

  // Reference model: a copy is len sequential word moves. Each move reads src+4i,
  // then writes that value to dst+4i.
  task automatic model_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    for (int i = 0; i < len; i++) begin
      logic [31:0] a, b, v;
      a = (src & 32'hFFFF_FFFC) + 32'(4 * i);
      b = (dst & 32'hFFFF_FFFC) + 32'(4 * i);
      v = ref_read(a);
      exp_q.push_back({1'b0, a, v});
      exp_q.push_back({1'b1, b, v});
      ref_mem[b] = v;
    end
  endtask

  // memory slave on the master port
  initial begin
    int wcnt;
    int wtgt;
    bit active;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'd0;
    wcnt = 0;
    wtgt = 0;
    active = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        wbm_ack_i = 1'b0;
        active = 1'b0;
      end else if (wbm_ack_i) begin
        wbm_ack_i = 1'b0;
      end else if (wbm_cyc_o && wbm_stb_o) begin
        if (!active) begin
          active = 1'b1;
          wcnt = 0;
          wtgt = fixed_wait ? max_wait : int'($urandom_range(0, max_wait));
        end
        if (wcnt < wtgt) begin
          wcnt++;
        end else begin
          wbm_ack_i = 1'b1;
          if (wbm_we_o) bus_mem[wbm_adr_o] = wbm_dat_o;
          else wbm_dat_i = bus_read(wbm_adr_o);
          active = 1'b0;
        end
      end
    end
  end

  // scoreboard / bus monitor on the master port
  logic        prev_stb, prev_ack, prev_we;
  logic [31:0] prev_adr, prev_dat;
  logic [64:0] cmp_e;
  always @(negedge clk) begin
    if (rst) begin
      prev_stb = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (wbm_cyc_o) cyc_cycles++;
      if (wbm_cyc_o || wbm_stb_o) begin
        check_eq("m_sel", 32'(wbm_sel_o), 32'hF);
        check_eq("m_cyc_eq_stb", 32'(wbm_cyc_o), 32'(wbm_stb_o));
      end
      if (prev_stb && prev_ack) check_eq("m_gap_after_ack", 32'(wbm_stb_o), 32'd0);
      if (prev_stb && !prev_ack && wbm_stb_o) begin
        check_eq("m_hold_adr", wbm_adr_o, prev_adr);
        check_eq("m_hold_dat", wbm_dat_o, prev_dat);
        check_eq("m_hold_we", 32'(wbm_we_o), 32'(prev_we));
      end
      if (wbm_stb_o && wbm_ack_i) begin
        check_eq("m_expected_cycle", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          cmp_e = exp_q.pop_front();
          check_eq("m_we", 32'(wbm_we_o), 32'(cmp_e[64]));
          check_eq("m_adr", wbm_adr_o, cmp_e[63:32]);
          if (cmp_e[64]) check_eq("m_dat", wbm_dat_o, cmp_e[31:0]);
        end
        if (wbm_we_o) wr_seen++;
      end
      prev_stb = wbm_stb_o;
      prev_ack = wbm_ack_i;
      prev_we  = wbm_we_o;
      prev_adr = wbm_adr_o;
      prev_dat = wbm_dat_o;
    end
  end

  // driver tasks for the CPU slave port
  task automatic cpu_access(input bit we, input logic [1:0] a, input logic [31:0] d,
                            output logic [31:0] q);
    int n;
    logic [23:0] junk;
    junk = 24'($urandom());
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = {junk, a}; wb_dat_i = d; wb_sel_i = 4'hF;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb_ack_o && n < 8);
    q = wb_dat_o;
    check_eq("s_ack_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    check_eq("s_no_back_to_back_ack", 32'(wb_ack_o), 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    cpu_access(1'b1, a, d, q);
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] q);
    cpu_access(1'b0, a, 32'd0, q);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_in_budget", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  int c0;

  initial begin
    rst = 1'b1;
    wb_adr_i = 26'd0; wb_dat_i = 32'd0; wb_we_i = 1'b0;
    wb_sel_i = 4'h0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset state
    check_eq("rst_cyc", 32'(wbm_cyc_o), 32'd0);
    check_eq("rst_stb", 32'(wbm_stb_o), 32'd0);
    check_eq("rst_we", 32'(wbm_we_o), 32'd0);
    check_eq("rst_adr", wbm_adr_o, 32'd0);
    check_eq("rst_dat", wbm_dat_o, 32'd0);
    check_eq("rst_sel", 32'(wbm_sel_o), 32'hF);
    check_eq("rst_ack", 32'(wb_ack_o), 32'd0);
    check_eq("rst_rdat", wb_dat_o, 32'd0);
    check_eq("rst_int", 32'(int_o), 32'd0);
    rst = 1'b0;

    // memory copy with literal data, zero-wait slave
    max_wait = 0; fixed_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus_mem[32'h4000_0000 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
      ref_mem[32'h4000_0000 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
    end
    model_copy(32'h4000_0000, 32'h4000_0100, 4);
    check_eq("model_pin_wr0_adr", exp_q[1][63:32], 32'h4000_0100);
    check_eq("model_pin_wr3_dat", exp_q[7][31:0], 32'h4444_4444);
    cpu_write(2'd0, 32'h4000_0000);
    cpu_write(2'd1, 32'h4000_0100);
    cpu_write(2'd2, 32'd4);
    cpu_write(2'd3, 32'h3);
    wait_drain(200);
    cpu_read(2'd3, rd);
    check_eq("copy_ctrl", rd, 32'h6);
    check_eq("copy_int", 32'(int_o), 32'd1);
    check_eq("copy_mem_last", bus_read(32'h4000_010C), 32'h4444_4444);
    cpu_read(2'd0, rd);
    check_eq("copy_src_kept", rd, 32'h4000_0000);
    cpu_write(2'd3, 32'h6);
    check_eq("clr_int_next", 32'(int_o), 32'd0);
    cpu_read(2'd3, rd);
    check_eq("clr_ctrl", rd, 32'h2);
    cpu_write(2'd3, 32'h0);

    // LEN=0 start: DONE only, no bus cycle
    cpu_write(2'd2, 32'd0);
    c0 = cyc_cycles;
    cpu_write(2'd3, 32'h1);
    cpu_read(2'd3, rd);
    check_eq("len0_ctrl", rd, 32'h4);
    repeat (10) @(posedge clk);
    check_eq("len0_no_cyc", 32'(cyc_cycles), 32'(c0));
    cpu_write(2'd3, 32'h4);

    // FILL bit handling
    cpu_write(2'd3, 32'h8);
    cpu_read(2'd3, rd);
`ifdef DMA_FILL_EN
    check_eq("fill_bit_rd", rd, 32'h8);
`else
    check_eq("fill_bit_rd", rd, 32'h0);
`endif
    cpu_write(2'd3, 32'h0);

    // address wrap past 2^32
    max_wait = 2; fixed_wait = 1'b0;
    model_copy(32'hFFFF_FFF8, 32'h0000_0FF8, 4);
    cpu_write(2'd0, 32'hFFFF_FFF8);
    cpu_write(2'd1, 32'h0000_0FF8);
    cpu_write(2'd2, 32'd4);
    cpu_write(2'd3, 32'h1);
    wait_drain(400);
    check_eq("wrap_mem", bus_read(32'h0000_1000), rom_val(32'h0000_0000));
    cpu_write(2'd3, 32'h4);

    // slave with 5 wait states
    max_wait = 5; fixed_wait = 1'b1;
    model_copy(32'h3000_0000, 32'h3000_1000, 2);
    cpu_write(2'd0, 32'h3000_0000);
    cpu_write(2'd1, 32'h3000_1000);
    cpu_write(2'd2, 32'd2);
    cpu_write(2'd3, 32'h1);
    wait_drain(400);
    cpu_read(2'd3, rd);
    check_eq("wait_ctrl", rd, 32'h4);
    cpu_write(2'd3, 32'h4);

    // register writes while busy are ignored
    max_wait = 4; fixed_wait = 1'b1;
    model_copy(32'h5000_0000, 32'h5000_0200, 3);
    cpu_write(2'd0, 32'h5000_0000);
    cpu_write(2'd1, 32'h5000_0200);
    cpu_write(2'd2, 32'd3);
    cpu_write(2'd3, 32'h1);
    cpu_write(2'd0, 32'hDEAD_BEEC);
    cpu_write(2'd2, 32'd7);
    cpu_write(2'd3, 32'h1);
    cpu_read(2'd3, rd);
    check_eq("busy_ctrl", rd, 32'h1);
    wait_drain(600);
    repeat (30) @(posedge clk);
    cpu_read(2'd0, rd);
    check_eq("busy_src_kept", rd, 32'h5000_0000);
    cpu_read(2'd2, rd);
    check_eq("busy_len_kept", rd, 32'd3);
    cpu_read(2'd3, rd);
    check_eq("busy_done", rd, 32'h4);

    // reset during the write of word 2 of 8 (DONE left set, IEN enabled)
    max_wait = 2; fixed_wait = 1'b1;
    model_copy(32'h6000_0000, 32'h6800_0000, 8);
    cpu_write(2'd0, 32'h6000_0000);
    cpu_write(2'd1, 32'h6800_0000);
    cpu_write(2'd2, 32'd8);
    wr_seen = 0;
    cpu_write(2'd3, 32'h3);
    c0 = 0;
    while (!(wr_seen == 1 && wbm_stb_o && wbm_we_o) && c0 < 300) begin
      @(posedge clk); #1;
      c0++;
    end
    check_eq("rst_reached_wr2", 32'(wr_seen == 1 && wbm_stb_o && wbm_we_o), 32'd1);
    check_eq("pre_rst_int", 32'(int_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_cyc", 32'(wbm_cyc_o), 32'd0);
    check_eq("midrst_int", 32'(int_o), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    c0 = cyc_cycles;
    for (int r = 0; r < 4; r++) begin
      cpu_read(2'(r), rd);
      check_eq("midrst_reg", rd, 32'd0);
    end
    check_eq("midrst_no_cyc", 32'(cyc_cycles), 32'(c0));

    // randomized transfers in one small, possibly overlapping window
    fixed_wait = 1'b0;
    for (int t = 0; t < 16; t++) begin
      logic [31:0] src, dst;
      int len;
      bit ien;
      max_wait = int'($urandom_range(0, 3));
      src = 32'h1000_0000 + 32'($urandom_range(0, 31) * 4);
      dst = 32'h1000_0000 + 32'($urandom_range(0, 31) * 4);
      len = int'($urandom_range(1, 6));
      ien = 1'($urandom_range(0, 1));
      model_copy(src, dst, len);
      cpu_write(2'd0, src | 32'($urandom_range(0, 3)));
      cpu_read(2'd0, rd);
      check_eq("rand_src_rd", rd, src);
      cpu_write(2'd1, dst);
      cpu_write(2'd2, 32'(len));
      cpu_write(2'd3, {30'd0, ien, 1'b1});
      wait_drain(1000);
      cpu_read(2'd3, rd);
      check_eq("rand_ctrl", rd, {29'd0, 1'b1, ien, 1'b0});
      check_eq("rand_int", 32'(int_o), 32'(ien));
      cpu_write(2'd3, {29'd0, 1'b1, ien, 1'b0});
      check_eq("rand_int_clr", 32'(int_o), 32'd0);
      cpu_write(2'd3, 32'h0);
    end
    for (int i = 0; i < 40; i++) begin
      check_eq("rand_mem", bus_read(32'h1000_0000 + 32'(4 * i)),
               ref_read(32'h1000_0000 + 32'(4 * i)));
    end

`ifdef DMA_FILL_EN
    // fill mode: writes of the SRC value only
    max_wait = 1; fixed_wait = 1'b0;
    exp_q.push_back({1'b1, 32'h2000_0000, 32'hA5A5_A5A5});
    exp_q.push_back({1'b1, 32'h2000_0004, 32'hA5A5_A5A5});
    cpu_write(2'd0, 32'hA5A5_A5A5);
    cpu_write(2'd1, 32'h2000_0000);
    cpu_write(2'd2, 32'd2);
    cpu_write(2'd3, 32'h9);
    wait_drain(300);
    cpu_read(2'd3, rd);
    check_eq("fill_ctrl", rd, 32'hC);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // time bound for the whole run
  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: run did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
